sync_fifo_gen: RTL and testbench

- Parametrised next-generation synchronous FIFO: configurable data width and depth.
- Selectable standard or first-word-fall-through (FWFT) read mode.
- Runtime-programmable almost-full/almost-empty thresholds, occupancy count output and synchronous flush.
- Drop-in buffer between producer and consumer in one clock domain; same status-flag set as the existing FIFO, extended.

---
 rtl/sync_fifo_gen_pkg.sv | 29 ++
 rtl/sync_fifo_gen_mem.sv | 30 +++
 rtl/sync_fifo_gen.sv | 131 +++++++++++++
 tb/tb_sync_fifo_gen.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_gen_pkg.sv
// Shared types and helpers for the sync_fifo_gen FIFO.
//   fifo_mode_e   : read-mode selector (standard / first-word-fall-through)
//   ptr_width()   : address width for a DEPTH-entry array (minimum 1)
//   cnt_width()   : width able to hold 0..DEPTH
//   clamp_thresh(): clamps a programmed threshold into [1, depth-1]
package sync_fifo_gen_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int unsigned ptr_width(int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int unsigned cnt_width(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // A threshold of 0 or >= depth would make the almost flags either never
  // fire or overlap full/empty, so the effective value is kept inside the band.
  function automatic int unsigned clamp_thresh(int unsigned value, int unsigned depth);
    if (value < 1)         return 1;
    if (value > depth - 1) return depth - 1;
    return value;
  endfunction

endpackage

// File: rtl/sync_fifo_gen_mem.sv
// Simple dual-port register array backing the FIFO.
//   clk   : write clock
//   we    : write enable, waddr/wdata : write port
//   raddr : asynchronous read address, rdata : read data
module sync_fifo_gen_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset on purpose -- contents are only ever read
  // behind a valid pointer/count, and a reset here would prevent RAM mapping.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_gen.sv
// Parametrised single-clock FIFO with standard or FWFT read mode,
// programmable almost-full/almost-empty thresholds and synchronous flush.
//   clk, rst (async, active high), flush (sync clear, highest priority)
//   wr_en/data_in          : write side
//   rd_en                  : read request (FWFT: pop head)
//   af_thresh/ae_thresh    : live almost-full / almost-empty thresholds
//   data_out/valid         : read data and its qualifier
//   wr_ack/overflow/underflow : one-cycle registered responses
//   full/empty/almostfull/almostempty/count : occupancy status
module sync_fifo_gen
  import sync_fifo_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int FWFT       = 0,
  parameter int CNT_W      = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic [CNT_W-1:0]      af_thresh,
  input  logic [CNT_W-1:0]      ae_thresh,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CNT_W-1:0]      count
);

  localparam int                 PTR_W    = ptr_width(DEPTH);
  localparam fifo_mode_e         MODE     = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rd_accept, write_accept;
  logic [CNT_W-1:0]      af_eff, ae_eff;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // A read frees a slot in the same edge, so a full FIFO may still take a write.
  // flush suppresses both requests.
  assign rd_accept    = rd_en && !empty && !flush;
  assign write_accept = wr_en && (!full || rd_accept) && !flush;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign af_eff = CNT_W'(clamp_thresh(32'(af_thresh), DEPTH));
  assign ae_eff = CNT_W'(clamp_thresh(32'(ae_thresh), DEPTH));
  assign almostfull  = !full  && (count >= af_eff);
  assign almostempty = !empty && (count <= ae_eff);

  sync_fifo_gen_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (write_accept),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= write_accept;
      overflow  <= wr_en && !write_accept;
      underflow <= rd_en && !rd_accept;
      if (write_accept) wr_ptr <= next_ptr(wr_ptr);
      if (rd_accept)    rd_ptr <= next_ptr(rd_ptr);
      case ({write_accept, rd_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  if (MODE == FIFO_FWFT) begin : g_fwft
    // Head is always presented; rd_en only advances rd_ptr.
    assign data_out = rdata;
    assign valid    = !empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (flush) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_accept;
        if (rd_accept) data_q <= rdata;
      end
    end

    assign data_out = data_q;
    assign valid    = valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_gen.sv
module tb_sync_fifo_gen;

  logic        clk = 1'b0;
  logic        rst, flush, wr_en, rd_en;
  logic [15:0] data_in;
  logic [3:0]  af_thresh, ae_thresh;

  // Standard mode, DEPTH=8
  logic [15:0] data_out1;
  logic        valid1, wr_ack1, overflow1, underflow1;
  logic        full1, empty1, af1, ae1;
  logic [3:0]  count1;

  // FWFT mode, DEPTH=5
  logic [15:0] data_out2;
  logic        valid2, wr_ack2, overflow2, underflow2;
  logic        full2, empty2, af2, ae2;
  logic [2:0]  count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_gen #(.DATA_WIDTH(16), .DEPTH(8), .FWFT(0)) dut_std (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .data_out(data_out1), .valid(valid1), .wr_ack(wr_ack1),
    .overflow(overflow1), .underflow(underflow1), .full(full1), .empty(empty1),
    .almostfull(af1), .almostempty(ae1), .count(count1)
  );

  sync_fifo_gen #(.DATA_WIDTH(16), .DEPTH(5), .FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .af_thresh(af_thresh[2:0]), .ae_thresh(ae_thresh[2:0]),
    .data_out(data_out2), .valid(valid2), .wr_ack(wr_ack2),
    .overflow(overflow2), .underflow(underflow2), .full(full2), .empty(empty2),
    .almostfull(af2), .almostempty(ae2), .count(count2)
  );

  typedef struct {
    logic        wr, rd, fl;
    logic [15:0] din;
    logic [3:0]  af, ae;
    logic [3:0]  cnt;
    logic [3:0]  flg;   // {full, empty, almostfull, almostempty}
    logic [2:0]  ack;   // {wr_ack, overflow, underflow}
    logic        vld;
    logic        chk;   // compare data_out
    logic [15:0] dout;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic wr, logic rd, logic fl, logic [15:0] din,
                              logic [3:0] af, logic [3:0] ae, logic [3:0] cnt,
                              logic [3:0] flg, logic [2:0] ack, logic vld,
                              logic chk, logic [15:0] dout);
    vec_t v;
    v.wr = wr; v.rd = rd; v.fl = fl; v.din = din; v.af = af; v.ae = ae;
    v.cnt = cnt; v.flg = flg; v.ack = ack; v.vld = vld; v.chk = chk; v.dout = dout;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_std(input string tag, input logic [3:0] cnt, input logic [3:0] flg,
                           input logic [2:0] ack, input logic vld);
    check({tag, " count"}, 32'(count1), 32'(cnt));
    check({tag, " flags"}, 32'({full1, empty1, af1, ae1}), 32'(flg));
    check({tag, " acks"},  32'({wr_ack1, overflow1, underflow1}), 32'(ack));
    check({tag, " valid"}, 32'(valid1), 32'(vld));
  endtask

  logic [15:0] q[$];

  initial begin
    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    af_thresh = 4'd6; ae_thresh = 4'd2;

    // ---------------- vector table (standard mode, DEPTH=8) ----------------
    for (int i = 1; i <= 8; i++)
      add(1, 0, 0, 16'(i), 6, 2, 4'(i), {i == 8, 1'b0, (i == 6 || i == 7), i <= 2},
          3'b100, 0, 0, 0);
    add(1, 0, 0, 16'h0009, 6, 2, 8, 4'b1000, 3'b010, 0, 0, 0);
    for (int i = 1; i <= 8; i++)
      add(0, 1, 0, 0, 6, 2, 4'(8 - i), {1'b0, i == 8, (i == 1 || i == 2), (i == 6 || i == 7)},
          3'b000, 1, 1, 16'(i));
    add(0, 1, 0, 0, 6, 2, 0, 4'b0100, 3'b001, 0, 1, 16'h0008);
    for (int i = 0; i < 8; i++)
      add(1, 0, 0, 16'(16'h10 + i), 6, 2, 4'(i + 1),
          {i == 7, 1'b0, (i == 5 || i == 6), i <= 1}, 3'b100, 0, 0, 0);
    add(1, 1, 0, 16'h0018, 6, 2, 8, 4'b1000, 3'b100, 1, 1, 16'h0010);
    add(0, 1, 0, 0, 6, 2, 7, 4'b0010, 3'b000, 1, 1, 16'h0011);
    add(0, 1, 0, 0, 6, 2, 6, 4'b0010, 3'b000, 1, 1, 16'h0012);
    add(0, 1, 0, 0, 6, 2, 5, 4'b0000, 3'b000, 1, 1, 16'h0013);
    add(1, 0, 1, 16'h0099, 6, 2, 0, 4'b0100, 3'b000, 0, 0, 0);
    add(1, 1, 0, 16'h0020, 6, 2, 1, 4'b0001, 3'b101, 0, 0, 0);
    add(0, 0, 0, 0, 0, 2, 1, 4'b0011, 3'b000, 0, 0, 0);
    for (int i = 2; i <= 8; i++)
      add(1, 0, 0, 16'(16'h20 + i), 0, 15, 4'(i), {i == 8, 1'b0, i < 8, i < 8},
          3'b100, 0, 0, 0);

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check_std("in_reset", 0, 4'b0100, 3'b000, 0);
    check("in_reset data", 32'(data_out1), 0);
    check("in_reset fwft empty", 32'({empty2, valid2, count2}), 32'({1'b1, 1'b0, 3'd0}));
    rst = 1'b0;
    @(negedge clk);
    check_std("after_reset", 0, 4'b0100, 3'b000, 0);

    // ---------------- table-driven run ----------------
    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      wr_en = vecs[k].wr; rd_en = vecs[k].rd; flush = vecs[k].fl;
      data_in = vecs[k].din; af_thresh = vecs[k].af; ae_thresh = vecs[k].ae;
      @(posedge clk); #1;
      check_std($sformatf("vec%0d", k), vecs[k].cnt, vecs[k].flg, vecs[k].ack, vecs[k].vld);
      if (vecs[k].chk) check($sformatf("vec%0d data", k), 32'(data_out1), 32'(vecs[k].dout));
    end

    // ---------------- async reset mid-operation ----------------
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; af_thresh = 4'd6; ae_thresh = 4'd2;
    rst = 1'b1;
    #1;
    check("async_rst count", 32'(count1), 0);
    check("async_rst flags", 32'({full1, empty1, wr_ack1}), 32'(3'b010));
    @(negedge clk);
    rst = 1'b0;

    // ---------------- FWFT, DEPTH=5 ----------------
    wr_en = 1'b1; data_in = 16'hA5A5;
    q.push_back(16'hA5A5);
    @(posedge clk); #1;
    check("fwft first data", 32'(data_out2), 32'h0000_A5A5);
    check("fwft first valid", 32'(valid2), 1);
    check("fwft first count", 32'(count2), 1);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      wr_en = 1'b1; data_in = 16'(16'h100 + i); rd_en = (i >= 2);
      if (rd_en) void'(q.pop_front());
      q.push_back(data_in);
      @(posedge clk); #1;
      check($sformatf("fwft wrap%0d data", i), 32'(data_out2), 32'(q[0]));
      check($sformatf("fwft wrap%0d count", i), 32'(count2), 32'(q.size()));
      check($sformatf("fwft wrap%0d valid", i), 32'(valid2), 1);
    end

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr_en = 1'b0; rd_en = 1'b1;
      void'(q.pop_front());
      @(posedge clk); #1;
      if (q.size() > 0)
        check($sformatf("fwft drain%0d data", i), 32'(data_out2), 32'(q[0]));
      check($sformatf("fwft drain%0d count", i), 32'(count2), 32'(q.size()));
    end
    check("fwft drained valid", 32'(valid2), 0);
    check("fwft drained empty", 32'(empty2), 1);

    @(negedge clk);
    rd_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
